mfp_uart_receiver_fifo: RTL and testbench
=========================================

// Module: mfp_uart_receiver_fifo
// PURPOSE
//  Parametrised UART receiver: configurable data bits, parity and stop bits.
//  3-sample majority vote per bit; false-start rejection; framing/parity/break detection.
//  Received characters plus per-character error flags go into an internal FIFO.
//  Sits behind the AHB-Lite UART slave, which pops the FIFO on RBR reads.
// PARAMETERS
//  CLOCK_FREQUENCY  50000000  clock frequency in Hz
//  BAUD_RATE        115200    line rate; CPB = CLOCK_FREQUENCY/BAUD_RATE (integer divide, CPB >= 8)
//  DATA_BITS        8         data bits per character, 5..9, LSB first on the line
//  PARITY           0         0 = none, 1 = odd, 2 = even
//  STOP_BITS        1         1 or 2
//  FIFO_AW          2         FIFO depth = 2**FIFO_AW entries
// PORTS
//  clock          in   1          system clock
//  reset_n        in   1          asynchronous, active-low reset
//  rx             in   1          serial line, asynchronous, idle high
//  rd_en          in   1          pop FIFO head; ignored when rd_valid = 0
//  rd_valid       out  1          FIFO not empty
//  rd_data        out  DATA_BITS  FIFO head data
//  rd_frame_err   out  1          FIFO head: a stop bit was sampled 0
//  rd_parity_err  out  1          FIFO head: parity mismatch (always 0 when PARITY = 0)
//  rd_break       out  1          FIFO head: data, parity and first stop bit all 0
//  fill_level     out  FIFO_AW+1  number of FIFO entries
//  overrun        out  1          1-cycle pulse: a character was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; state WAIT_IDLE; rx synchronisers set to 1.
//  Input: rx passes through a 2-flop synchroniser (rx_s). Start edge = rx_s 1 -> 0.
//  Bit timer: counts 0..CPB-1 from the start-edge cycle (that cycle = count 0).
//  Bit value = majority of rx_s at counts CPB/2-1, CPB/2 and CPB/2+1.
//    The bit is decided at count CPB/2+1.
//  FSM:
//   WAIT_IDLE -> IDLE when rx_s = 1.
//   IDLE -> START on start edge.
//   START: decided value 1 = false start -> IDLE (nothing pushed). Value 0 -> DATA at count CPB-1.
//   DATA: DATA_BITS bits shifted in LSB first. Then -> PARITY (PARITY != 0) or STOP.
//   PARITY: odd mode: data ones + parity bit must total odd. Even mode: must total even.
//   STOP: STOP_BITS bits. Any stop bit 0 sets frame_err.
//  End of frame:
//   Push happens on the edge where the last stop bit is decided (mid-bit).
//   With no frame error -> IDLE at that edge, so the next start edge can follow immediately.
//   With frame_err -> WAIT_IDLE, so a held-low line or break produces exactly one entry.
//  FIFO entry = {break, parity_err, frame_err, data}.
//  FIFO timing:
//   rd_valid, rd_* and fill_level update on the push edge (registered count, no extra latency).
//   Pop: rd_en = 1 with rd_valid = 1 removes the head at the clock edge.
//   Push when full with no pop: character dropped, FIFO unchanged, overrun = 1 for one cycle.
//   Push and pop in the same cycle when full: both occur, no overrun, fill_level unchanged.
//   Push and pop in the same cycle when not empty: fill_level unchanged.
//   Pointers wrap modulo 2**FIFO_AW. fill_level counts 0..2**FIFO_AW.
//  Reset asserted mid-frame: the frame is discarded and the FIFO cleared.
//   After release, a low rx is not treated as a start until rx_s has been seen high.
// TESTING (CLOCK_FREQUENCY=1000000, BAUD_RATE=100000 -> CPB=10; FIFO_AW=2 unless stated)
//  8N1 0xA5, no reads -> rd_valid=1 at mid stop bit; rd_data=0xA5; all error flags 0; fill_level=1.
//  8E1 0x07 with parity bit 0 -> rd_data=0x07, rd_parity_err=1. Same byte with parity bit 1 -> rd_parity_err=0.
//  0-pulse of 3 clocks on idle line -> false start; rd_valid stays 0; FSM back in IDLE.
//  8N2: 0x3C with second stop bit 0 -> rd_frame_err=1. Line held low for 30 bit times -> exactly one
//    entry (0x00, frame_err=1, break=1); next byte is accepted only after the line returns high.
//  5 back-to-back bytes 0x01..0x05, no reads -> fill_level=4, overrun pulses once on 5th,
//    pops return 0x01..0x04. Repeat with rd_en held high at the 5th push -> no overrun.
//  Assert reset_n low during bit 4 of a frame while rx stays low -> fill_level=0, all outputs 0;
//    no entry until a fresh frame after idle.
//  Bit glitch: a single-cycle inversion at count CPB/2 of a data bit -> correct byte received (majority vote).

Source files
------------

// File: rtl/mfp_uart_receiver_fifo.sv
// mfp_uart_receiver_fifo: UART receiver with 3-sample majority vote, false-start rejection,
// framing/parity/break detection and a small FIFO of characters with per-character flags.
module mfp_uart_receiver_fifo #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int BAUD_RATE       = 115200,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_AW         = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 rd_en,
  output logic                 rd_valid,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_frame_err,
  output logic                 rd_parity_err,
  output logic                 rd_break,
  output logic [FIFO_AW:0]     fill_level,
  output logic                 overrun
);
  localparam int CPB   = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int H     = CPB / 2;
  localparam int CW    = $clog2(CPB);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int EW    = DATA_BITS + 3;

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, PAR, STOP} state_t;
  state_t state, state_n;

  logic rx_m, rx_s, rx_d;
  logic [1:0] warm;
  logic [CW-1:0] cnt;
  logic s0, s1, maj, mid, last, start_edge, push, wr, pop, full;
  logic [3:0] bit_idx;
  logic stop_idx, stop0, par_bit, par_err, frame_err;
  logic [DATA_BITS-1:0] shreg;
  logic [EW-1:0] entry;
  logic [EW-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;

  assign maj        = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign mid        = cnt == CW'(H + 1);
  assign last       = cnt == CW'(CPB - 1);
  assign start_edge = rx_d & ~rx_s;
  assign entry      = {(shreg == '0) & ~par_bit & ~(stop_idx ? stop0 : maj), par_err, frame_err | ~maj, shreg};

  always_comb begin
    state_n = state;
    push    = 1'b0;
    case (state)
      WAIT_IDLE: state_n = (rx_s & warm[1]) ? IDLE : WAIT_IDLE;
      IDLE:      state_n = start_edge ? START : IDLE;
      START:     state_n = (mid & maj) ? IDLE : last ? DATA : START;
      DATA:      state_n = (last && bit_idx == 4'(DATA_BITS - 1)) ? ((PARITY != 0) ? PAR : STOP) : DATA;
      PAR:       state_n = last ? STOP : PAR;
      STOP: if (mid && stop_idx == 1'(STOP_BITS - 1)) begin
        push    = 1'b1;
        state_n = (frame_err | ~maj) ? WAIT_IDLE : IDLE;
      end
      default:   state_n = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= WAIT_IDLE;
    else state <= state_n;

  // warm masks the preset synchroniser value so a line held low through reset is never a start
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      {rx_m, rx_s, rx_d} <= 3'b111;
      warm <= '0;
    end else begin
      {rx_m, rx_s, rx_d} <= {rx, rx_m, rx_s};
      warm <= {warm[0], 1'b1};
    end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      {s0, s1, stop_idx, stop0, par_bit, par_err, frame_err} <= '0;
      bit_idx <= '0;
      shreg <= '0;
    end else begin
      cnt <= (state == IDLE) ? CW'(start_edge) : (state == WAIT_IDLE || last) ? '0 : cnt + 1'b1;
      if (cnt == CW'(H - 1)) s0 <= rx_s;
      if (cnt == CW'(H)) s1 <= rx_s;
      if (state == IDLE) begin
        bit_idx <= '0;
        {stop_idx, par_bit, par_err, frame_err} <= '0;
      end
      if (state == DATA && mid) shreg <= {maj, shreg[DATA_BITS-1:1]};
      if (state == DATA && last) bit_idx <= bit_idx + 1'b1;
      if (state == PAR && mid) begin
        par_bit <= maj;
        par_err <= (^shreg ^ maj) ^ (PARITY == 1);
      end
      if (state == STOP && mid) begin
        frame_err <= frame_err | ~maj;
        if (!stop_idx) stop0 <= maj;
      end
      if (state == STOP && last) stop_idx <= 1'b1;
    end

  assign full     = fill_level == (FIFO_AW + 1)'(DEPTH);
  assign rd_valid = fill_level != '0;
  assign pop      = rd_en & rd_valid;
  assign wr       = push & (~full | pop);
  assign {rd_break, rd_parity_err, rd_frame_err, rd_data} = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock)
    if (wr) mem[wr_ptr] <= entry;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      overrun    <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + FIFO_AW'(wr);
      rd_ptr     <= rd_ptr + FIFO_AW'(pop);
      fill_level <= fill_level + (FIFO_AW + 1)'(wr) - (FIFO_AW + 1)'(pop);
      overrun    <= push & full & ~pop;
    end
endmodule

// File: tb/tb_mfp_uart_receiver_fifo.sv
// tb_mfp_uart_receiver_fifo: directed bench for 8N1, 8E1 and 8N2 receivers at 10 clocks per bit,
// with expected FIFO entries queued as frames are sent and compared as they are popped.
module tb_mfp_uart_receiver_fifo;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;
  logic [2:0] rx, rd_en, rd_valid, fe, pe, brk, ov;
  logic [2:0][7:0] rd_data;
  logic [2:0][2:0] fill;
  int errors = 0, checks = 0, ov_total = 0, base;
  logic [10:0] q[$];

  mfp_uart_receiver_fifo #(.CLOCK_FREQUENCY(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_AW(2)) u_8n1 (
    .clock(clock), .reset_n(reset_n), .rx(rx[0]), .rd_en(rd_en[0]), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]),
    .rd_frame_err(fe[0]), .rd_parity_err(pe[0]), .rd_break(brk[0]), .fill_level(fill[0]), .overrun(ov[0]));
  mfp_uart_receiver_fifo #(.CLOCK_FREQUENCY(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_AW(2)) u_8e1 (
    .clock(clock), .reset_n(reset_n), .rx(rx[1]), .rd_en(rd_en[1]), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]),
    .rd_frame_err(fe[1]), .rd_parity_err(pe[1]), .rd_break(brk[1]), .fill_level(fill[1]), .overrun(ov[1]));
  mfp_uart_receiver_fifo #(.CLOCK_FREQUENCY(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_AW(2)) u_8n2 (
    .clock(clock), .reset_n(reset_n), .rx(rx[2]), .rd_en(rd_en[2]), .rd_valid(rd_valid[2]), .rd_data(rd_data[2]),
    .rd_frame_err(fe[2]), .rd_parity_err(pe[2]), .rd_break(brk[2]), .fill_level(fill[2]), .overrun(ov[2]));

  always @(negedge clock) if (ov[0]) ov_total++;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clock);
  endtask

  // frame bits LSB first, 10 clocks each; bit gi gets a one-clock inversion at mid-bit
  task automatic send(int d, logic [15:0] f, int n, int gi = -1);
    for (int i = 0; i < n; i++) begin
      rx[d] = f[i];
      if (i == gi) begin
        tick(5); rx[d] = ~f[i]; tick(1); rx[d] = f[i]; tick(4);
      end else tick(10);
    end
  endtask

  task automatic pop_chk(int d, string tag);
    logic [10:0] e;
    e = (q.size() != 0) ? q.pop_front() : 11'h7ff;
    chk({tag, ".valid"}, 32'(rd_valid[d]), 1);
    chk({tag, ".entry"}, {brk[d], pe[d], fe[d], rd_data[d]}, 32'(e));
    rd_en[d] = 1'b1;
    tick(1);
    rd_en[d] = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    rx = '1;
    rd_en = '0;
    tick(3);
    chk("rst.flags", {rd_valid, fe, pe, brk, ov}, 0);
    chk("rst.data", 32'(rd_data), 0);
    chk("rst.fill", 32'(fill), 0);
    reset_n = 1'b1;
    tick(5);

    q.push_back({3'b000, 8'hA5});
    send(0, {7'h0, 8'hA5, 1'b0}, 9);
    rx[0] = 1'b1;
    tick(8);
    chk("8n1.before_mid", 32'(rd_valid[0]), 0);
    tick(1);
    chk("8n1.at_mid", 32'(rd_valid[0]), 1);
    chk("8n1.fill", 32'(fill[0]), 1);
    tick(1);
    pop_chk(0, "8n1");
    chk("8n1.empty", 32'(fill[0]), 0);

    q.push_back({3'b010, 8'h07});
    send(1, {5'h0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    pop_chk(1, "8e1.bad");
    q.push_back({3'b000, 8'h07});
    send(1, {5'h0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    pop_chk(1, "8e1.good");

    rx[0] = 1'b0;
    tick(3);
    rx[0] = 1'b1;
    tick(30);
    chk("fs.valid", 32'(rd_valid[0]), 0);
    chk("fs.fill", 32'(fill[0]), 0);
    q.push_back({3'b000, 8'h5A});
    send(0, {6'h0, 1'b1, 8'h5A, 1'b0}, 10);
    pop_chk(0, "fs.next");

    q.push_back({3'b001, 8'h3C});
    send(2, {5'h0, 1'b0, 1'b1, 8'h3C, 1'b0}, 11);
    rx[2] = 1'b1;
    tick(20);
    pop_chk(2, "8n2.fe");
    q.push_back({3'b101, 8'h00});
    rx[2] = 1'b0;
    tick(300);
    chk("brk.fill", 32'(fill[2]), 1);
    pop_chk(2, "brk");
    tick(20);
    chk("brk.low_no_entry", 32'(fill[2]), 0);
    rx[2] = 1'b1;
    tick(20);
    q.push_back({3'b000, 8'h81});
    send(2, {5'h0, 2'b11, 8'h81, 1'b0}, 11);
    pop_chk(2, "brk.next");

    base = ov_total;
    for (int i = 1; i <= 5; i++) begin
      if (i < 5) q.push_back({3'b000, 8'(i)});
      send(0, {6'h0, 1'b1, 8'(i), 1'b0}, 10);
    end
    chk("ovr.pulses", 32'(ov_total - base), 1);
    chk("ovr.fill", 32'(fill[0]), 4);
    for (int i = 0; i < 4; i++) pop_chk(0, "ovr.pop");
    chk("ovr.empty", 32'(fill[0]), 0);

    base = ov_total;
    for (int i = 1; i <= 4; i++) begin
      q.push_back({3'b000, 8'(8'h10 + i)});
      send(0, {6'h0, 1'b1, 8'(8'h10 + i), 1'b0}, 10);
    end
    q.push_back({3'b000, 8'h15});
    send(0, {7'h0, 8'h15, 1'b0}, 9);
    rx[0] = 1'b1;
    tick(8);
    pop_chk(0, "ovr2.head");
    tick(1);
    chk("ovr2.pulses", 32'(ov_total - base), 0);
    chk("ovr2.fill", 32'(fill[0]), 4);
    for (int i = 0; i < 4; i++) pop_chk(0, "ovr2.pop");

    send(0, {6'h0, 1'b1, 8'h77, 1'b0}, 10);
    chk("rst2.pre_fill", 32'(fill[0]), 1);
    rx[0] = 1'b0;
    tick(45);
    reset_n = 1'b0;
    tick(2);
    chk("rst2.fill", 32'(fill[0]), 0);
    chk("rst2.out", {rd_valid[0], rd_data[0], fe[0], pe[0], brk[0], ov[0]}, 0);
    reset_n = 1'b1;
    tick(200);
    chk("rst2.low_no_entry", 32'(fill[0]), 0);
    rx[0] = 1'b1;
    tick(20);
    q.push_back({3'b000, 8'hC3});
    send(0, {6'h0, 1'b1, 8'hC3, 1'b0}, 10);
    pop_chk(0, "rst2.fresh");

    q.push_back({3'b000, 8'h96});
    send(0, {6'h0, 1'b1, 8'h96, 1'b0}, 10, 3);
    pop_chk(0, "glitch.hi");
    q.push_back({3'b000, 8'h96});
    send(0, {6'h0, 1'b1, 8'h96, 1'b0}, 10, 1);
    pop_chk(0, "glitch.lo");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
